// File: rtl/fas_frame_sched.sv
// Front-end frame scheduler for the FFT analysis path: ping-pong collection of
// 16-sample frames, gated launch into the FFT engine, and frame-ID tagging of results.
module fas_frame_sched #(
  parameter int DW           = 16,
  parameter int NPTS         = 16,
  parameter int ID_W         = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              smp_valid,
  input  logic [DW-1:0]                     smp_data,
  input  logic                              fft_ready,
  output logic                              fft_start,
  output logic [NPTS*DW-1:0]                fft_frame,
  input  logic                              ana_done,
  input  logic [3:0]                        ana_freq,
  output logic                              res_valid,
  output logic [3:0]                        res_freq,
  output logic [ID_W-1:0]                   res_id,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              overflow,
  output logic                              err,
  input  logic                              clr_ovf,
  output logic                              busy
);

  localparam int PTR_W = $clog2(NPTS);
  localparam int FP_W  = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = FP_W + 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NPTS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);

  logic [DW-1:0]        bank_q [2][NPTS];
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, rd_bank_q;
  logic [PTR_W-1:0]     wr_ptr_q;

  logic [ID_W-1:0]      next_id_q;
  logic [ID_W-1:0]      id_fifo_q [MAX_INFLIGHT];
  logic [FP_W-1:0]      fifo_wp_q, fifo_rp_q;
  logic [CNT_W-1:0]     inflight_q, inflight_d;

  logic                 fft_start_q;
  logic [NPTS*DW-1:0]   fft_frame_q, frame_flat;
  logic                 res_valid_q;
  logic [3:0]           res_freq_q;
  logic [ID_W-1:0]      res_id_q;
  logic                 overflow_q, err_q;

  logic smp_write, smp_drop, issue, done_ok, done_spur;

  // Fullness is judged on pre-edge state, so a sample meeting a full write
  // bank is dropped even if that bank is being issued in the same cycle.
  assign smp_write = smp_valid & ~full_q[wr_bank_q];
  assign smp_drop  = smp_valid &  full_q[wr_bank_q];
  assign issue     = full_q[rd_bank_q] & fft_ready & (inflight_q < MAX_CNT) & ~fft_start_q;
  assign done_ok   = ana_done & (inflight_q != '0);
  assign done_spur = ana_done & (inflight_q == '0);

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    full_d     = full_q;
    inflight_d = inflight_q;
    frame_flat = '0;
    if (issue) full_d[rd_bank_q] = 1'b0;
    if (smp_write && wr_ptr_q == LAST_SLOT) full_d[wr_bank_q] = 1'b1;
    case ({issue, done_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    for (int k = 0; k < NPTS; k++) begin
      frame_flat[k*DW +: DW] = bank_q[rd_bank_q][k];
    end
  end

  // NOTE: sample banks and the ID FIFO are plain storage with no reset; the
  // full flags and FIFO pointers alone decide whether their contents are valid.
  always_ff @(posedge clk) begin
    if (smp_write) bank_q[wr_bank_q][wr_ptr_q] <= smp_data;
    if (issue)     id_fifo_q[fifo_wp_q]        <= next_id_q;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      next_id_q   <= '0;
      fifo_wp_q   <= '0;
      fifo_rp_q   <= '0;
      inflight_q  <= '0;
      fft_start_q <= 1'b0;
      fft_frame_q <= '0;
      res_valid_q <= 1'b0;
      res_freq_q  <= '0;
      res_id_q    <= '0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      full_q      <= full_d;
      inflight_q  <= inflight_d;
      fft_start_q <= issue;
      res_valid_q <= done_ok;

      if (smp_write) begin
        if (wr_ptr_q == LAST_SLOT) begin
          wr_ptr_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        end
      end

      if (issue) begin
        fft_frame_q <= frame_flat;
        rd_bank_q   <= ~rd_bank_q;
        next_id_q   <= next_id_q + ID_W'(1);
        fifo_wp_q   <= fifo_wp_q + FP_W'(1);
      end

      if (done_ok) begin
        fifo_rp_q  <= fifo_rp_q + FP_W'(1);
        res_freq_q <= ana_freq;
        res_id_q   <= id_fifo_q[fifo_rp_q];
      end

      // Set beats clear when both land in the same cycle.
      if (smp_drop)     overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
      if (done_spur)    err_q <= 1'b1;
      else if (clr_ovf) err_q <= 1'b0;
    end
  end

  assign fft_start = fft_start_q;
  assign fft_frame = fft_frame_q;
  assign res_valid = res_valid_q;
  assign res_freq  = res_freq_q;
  assign res_id    = res_id_q;
  assign inflight  = inflight_q;
  assign overflow  = overflow_q;
  assign err       = err_q;
  assign busy      = (wr_ptr_q != '0) | (|full_q) | (inflight_q != '0);

endmodule

// File: tb/tb_fas_frame_sched.sv
// Directed self-checking bench for fas_frame_sched: fill, drop, in-flight limit,
// simultaneous issue/done, spurious done and mid-frame reset.
module tb_fas_frame_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         smp_valid;
  logic [15:0]  smp_data;
  logic         fft_ready;
  logic         fft_start;
  logic [255:0] fft_frame;
  logic         ana_done;
  logic [3:0]   ana_freq;
  logic         res_valid;
  logic [3:0]   res_freq;
  logic [7:0]   res_id;
  logic [2:0]   inflight;
  logic         overflow;
  logic         err;
  logic         clr_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int res_cnt = 0;
  int adj_cnt = 0;
  logic prev_start = 1'b0;
  int base;

  fas_frame_sched dut (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .fft_ready (fft_ready),
    .fft_start (fft_start),
    .fft_frame (fft_frame),
    .ana_done  (ana_done),
    .ana_freq  (ana_freq),
    .res_valid (res_valid),
    .res_freq  (res_freq),
    .res_id    (res_id),
    .inflight  (inflight),
    .overflow  (overflow),
    .err       (err),
    .clr_ovf   (clr_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observe pulses on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (fft_start) start_cnt++;
    if (fft_start && prev_start) adj_cnt++;
    prev_start = fft_start;
    if (res_valid) res_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; smp_valid = 1'b0; smp_data = '0; fft_ready = 1'b0;
    ana_done = 1'b0; ana_freq = '0; clr_ovf = 1'b0;
    #2;
    check("rst_start",    fft_start, 0);
    check("rst_frame",    fft_frame, 0);
    check("rst_resvalid", res_valid, 0);
    check("rst_inflight", inflight,  0);
    check("rst_ovf",      overflow,  0);
    check("rst_err",      err,       0);
    check("rst_busy",     busy,      0);
    tick();
    rst = 1'b0;

    // 1: one frame, latency and frame layout
    fft_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(16'(i));
    check("t1_no_start_yet", fft_start, 0);
    tick();
    check("t1_start",    fft_start,         1);
    check("t1_slot0",    fft_frame[15:0],   16'h0001);
    check("t1_slot15",   fft_frame[255:240], 16'h0010);
    check("t1_inflight", inflight,          1);
    check("t1_busy",     busy,              1);
    tick();
    check("t1_start_low", fft_start, 0);
    check("t1_start_cnt", start_cnt, 1);

    // 2: both banks full, drops, then two spaced starts
    do_reset();
    fft_ready = 1'b0;
    base = start_cnt;
    for (int i = 1; i <= 40; i++) send(16'(i));
    tick();
    check("t2_ovf",      overflow,          1);
    check("t2_no_start", start_cnt - base,  0);
    fft_ready = 1'b1;
    tick();
    check("t2_start_a",  fft_start,          1);
    check("t2_a_slot0",  fft_frame[15:0],    16'd1);
    check("t2_a_slot15", fft_frame[255:240], 16'd16);
    tick();
    check("t2_gap",      fft_start,          0);
    tick();
    check("t2_start_b",  fft_start,          1);
    check("t2_b_slot0",  fft_frame[15:0],    16'd17);
    check("t2_b_slot15", fft_frame[255:240], 16'd32);
    check("t2_inflight", inflight,           2);
    tick();
    ana_done = 1'b1; ana_freq = 4'd3;
    tick();
    ana_done = 1'b0;
    check("t2_res_v0",   res_valid, 1);
    check("t2_res_id0",  res_id,    0);
    check("t2_res_f0",   res_freq,  3);
    check("t2_inflt1",   inflight,  1);
    tick();
    check("t2_res_pulse", res_valid, 0);
    check("t2_res_hold",  res_freq,  3);
    ana_done = 1'b1; ana_freq = 4'd5;
    tick();
    ana_done = 1'b0;
    check("t2_res_id1",  res_id,   1);
    check("t2_res_f1",   res_freq, 5);
    check("t2_ovf_held", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t2_ovf_clr",  overflow, 0);
    check("t2_idle",     busy,     0);

    // 3: in-flight limit holds the 5th frame
    do_reset();
    fft_ready = 1'b1;
    base = start_cnt;
    for (int f = 1; f <= 5; f++)
      for (int s = 0; s < 16; s++) send(16'((f << 8) | s));
    tick();
    tick();
    check("t3_four_starts", start_cnt - base,   4);
    check("t3_inflight4",   inflight,           4);
    check("t3_frame4_lo",   fft_frame[15:0],    16'h0400);
    check("t3_frame4_hi",   fft_frame[255:240], 16'h040f);
    check("t3_no_ovf",      overflow,           0);
    ana_done = 1'b1; ana_freq = 4'd7;
    tick();
    ana_done = 1'b0;
    check("t3_res_v",     res_valid, 1);
    check("t3_res_id",    res_id,    0);
    check("t3_res_f",     res_freq,  7);
    check("t3_inflight3", inflight,  3);
    check("t3_no_start",  fft_start, 0);
    tick();
    check("t3_start5",    fft_start,       1);
    check("t3_frame5_lo", fft_frame[15:0], 16'h0500);
    check("t3_inflight4b", inflight,       4);

    // 4: issue and done in the same cycle
    tick();
    ana_done = 1'b1; ana_freq = 4'd1;
    tick();
    check("t4_res_id1", res_id, 1);
    ana_freq = 4'd2;
    tick();
    ana_done = 1'b0;
    check("t4_res_id2",    res_id,   2);
    check("t4_inflight2",  inflight, 2);
    fft_ready = 1'b0;
    for (int s = 0; s < 16; s++) send(16'h0600 | 16'(s));
    tick();
    check("t4_held", fft_start, 0);
    fft_ready = 1'b1; ana_done = 1'b1; ana_freq = 4'd9;
    tick();
    check("t4_both_start", fft_start,       1);
    check("t4_both_res",   res_valid,       1);
    check("t4_both_id",    res_id,          3);
    check("t4_both_freq",  res_freq,        9);
    check("t4_inflt_same", inflight,        2);
    check("t4_frame6",     fft_frame[15:0], 16'h0600);
    ana_freq = 4'd10;
    tick();
    check("t4_res_id4", res_id,   4);
    check("t4_inflt1",  inflight, 1);
    ana_freq = 4'd11;
    tick();
    ana_done = 1'b0;
    check("t4_res_id5", res_id,   5);
    check("t4_res_f11", res_freq, 11);
    check("t4_inflt0",  inflight, 0);
    tick();

    // 5: spurious done, set beats clear
    base = res_cnt;
    ana_done = 1'b1; ana_freq = 4'd2;
    tick();
    ana_done = 1'b0;
    check("t5_err",      err,       1);
    check("t5_no_res",   res_valid, 0);
    check("t5_inflt0",   inflight,  0);
    tick();
    clr_ovf = 1'b1; ana_done = 1'b1;
    tick();
    clr_ovf = 1'b0; ana_done = 1'b0;
    check("t5_set_wins", err, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t5_err_clr",  err, 0);
    tick();
    check("t5_res_cnt",  res_cnt - base, 0);

    // 6: asynchronous reset in mid-frame
    for (int s = 0; s < 7; s++) send(16'h0700 | 16'(s));
    check("t6_busy_partial", busy, 1);
    rst = 1'b1;
    #2;
    check("t6_async_busy", busy,   0);
    check("t6_async_id",   res_id, 0);
    check("t6_async_freq", res_freq, 0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 16; s++) send(16'h0800 | 16'(s));
    tick();
    check("t6_start",    fft_start,          1);
    check("t6_slot0",    fft_frame[15:0],    16'h0800);
    check("t6_slot15",   fft_frame[255:240], 16'h080f);
    ana_done = 1'b1; ana_freq = 4'd4;
    tick();
    ana_done = 1'b0;
    check("t6_res_v",  res_valid, 1);
    check("t6_res_id", res_id,    0);
    check("t6_res_f",  res_freq,  4);
    tick();
    check("no_adjacent_starts", adj_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
